// File: rtl/reg_bank_dump_ctrl_pkg.sv
// Shared definitions for the register-bank dump sequencer.
//   - dump_state_t   : sequencer state encoding (3 bits)
//   - bytes_per_word : number of TX bytes that make up one register word
//   - idx_width      : width of a counter over N items, never below 1 bit
package reg_bank_dump_ctrl_pkg;

  localparam int DATA_SIZE_DEF  = 32;
  localparam int ADDR_SIZE_DEF  = 5;
  localparam int BANK_DEPTH_DEF = 32;
  localparam int BYTE_SIZE_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_LATCH   = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT_TX = 3'd4,
    ST_DONE    = 3'd5
  } dump_state_t;

  function automatic int bytes_per_word(input int data_size, input int byte_size);
    return data_size / byte_size;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int BYTES_PER_WORD = bytes_per_word(DATA_SIZE_DEF, BYTE_SIZE_DEF);

endpackage

// File: rtl/reg_bank_dump_ctrl_if.sv
// Bus bundle between the dump sequencer, the register bank debug read port
// and the UART transmitter. Signal names are seen from the sequencer side.
//   o_bank_read_enable / o_bank_read_addr : bank debug read request
//   i_bank_data                           : bank data, valid 1 cycle after request
//   o_tx_start / o_tx_data                : byte launch to the UART TX
//   i_tx_busy / i_tx_done                 : UART TX status
//
// TX handshake: o_tx_start is a single-cycle pulse raised only while
// i_tx_busy is low; o_tx_data is valid in that cycle and stays unchanged
// until the TX answers with a single-cycle i_tx_done. Only one byte is ever
// outstanding; i_tx_done seen in any other phase carries no meaning.
interface reg_bank_dump_ctrl_if #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 5,
  parameter int BYTE_SIZE = 8
);
  logic                 o_bank_read_enable;
  logic [ADDR_SIZE-1:0] o_bank_read_addr;
  logic [DATA_SIZE-1:0] i_bank_data;
  logic                 i_tx_busy;
  logic                 i_tx_done;
  logic                 o_tx_start;
  logic [BYTE_SIZE-1:0] o_tx_data;

  // Sequencer side
  modport master (
    output o_bank_read_enable, o_bank_read_addr, o_tx_start, o_tx_data,
    input  i_bank_data, i_tx_busy, i_tx_done
  );

  // Bank + TX side
  modport slave (
    input  o_bank_read_enable, o_bank_read_addr, o_tx_start, o_tx_data,
    output i_bank_data, i_tx_busy, i_tx_done
  );
endinterface

// File: rtl/reg_bank_dump_ctrl_word_serializer.sv
// Holds one captured register word and steps through it byte by byte,
// least-significant byte first.
//   i_clock, i_reset : clock, async active-low reset
//   load_i           : capture word_i and point at byte 0
//   advance_i        : move to the next byte
//   clear_i          : point back at byte 0 (has priority)
//   word_i           : word to capture
//   byte_o           : currently selected byte
//   last_o           : selected byte is the word's most-significant byte
module reg_bank_dump_ctrl_word_serializer
  import reg_bank_dump_ctrl_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int BYTE_SIZE = 8
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 load_i,
  input  logic                 advance_i,
  input  logic                 clear_i,
  input  logic [DATA_SIZE-1:0] word_i,
  output logic [BYTE_SIZE-1:0] byte_o,
  output logic                 last_o
);

  localparam int BPW = bytes_per_word(DATA_SIZE, BYTE_SIZE);
  localparam int IW  = idx_width(BPW);

  // Packed as bytes so the byte mux is a plain index.
  logic [BPW-1:0][BYTE_SIZE-1:0] word_q, word_d;
  logic [IW-1:0]                 byte_idx_q, byte_idx_d;

  always_comb begin
    word_d     = word_q;
    byte_idx_d = byte_idx_q;
    if (clear_i) begin
      byte_idx_d = '0;
    end else if (load_i) begin
      word_d     = word_i;
      byte_idx_d = '0;
    end else if (advance_i) begin
      byte_idx_d = byte_idx_q + IW'(1);
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      word_q     <= '0;
      byte_idx_q <= '0;
    end else begin
      word_q     <= word_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  assign byte_o = word_q[byte_idx_q];
  assign last_o = (byte_idx_q == IW'(BPW - 1));

endmodule

// File: rtl/reg_bank_dump_ctrl.sv
// Debug-unit sequencer that dumps the whole register bank over the UART TX
// while the pipeline is halted: read register, capture it, send its bytes
// LSB first, repeat for every address, then pulse o_done.
//   i_clock, i_reset : clock, async active-low reset
//   i_start          : dump request pulse (accepted only when idle and halted)
//   i_halted         : pipeline halted; dropping it mid-dump cancels the dump
//   i_abort          : cancel an in-progress dump
//   o_busy           : dump in progress (including the DONE cycle)
//   o_done           : one-cycle pulse when the last byte has been sent
//   o_state_dbg      : current sequencer state
//   bus              : bank read port and UART TX signals
module reg_bank_dump_ctrl
  import reg_bank_dump_ctrl_pkg::*;
#(
  parameter int DATA_SIZE  = 32,
  parameter int ADDR_SIZE  = 5,
  parameter int BANK_DEPTH = 32,
  parameter int BYTE_SIZE  = 8
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_halted,
  input  logic        i_abort,
  output logic        o_busy,
  output logic        o_done,
  output dump_state_t o_state_dbg,
  reg_bank_dump_ctrl_if.master bus
);

  localparam logic [ADDR_SIZE-1:0] LAST_REG = ADDR_SIZE'(BANK_DEPTH - 1);

  dump_state_t          state_q, state_d;
  logic [ADDR_SIZE-1:0] reg_idx_q, reg_idx_d;

  logic                 ser_load, ser_advance, ser_clear;
  logic [BYTE_SIZE-1:0] ser_byte;
  logic                 ser_last;
  logic                 cancel;

  reg_bank_dump_ctrl_word_serializer #(
    .DATA_SIZE (DATA_SIZE),
    .BYTE_SIZE (BYTE_SIZE)
  ) u_ser (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .load_i    (ser_load),
    .advance_i (ser_advance),
    .clear_i   (ser_clear),
    .word_i    (bus.i_bank_data),
    .byte_o    (ser_byte),
    .last_o    (ser_last)
  );

  // Losing halt is handled exactly like an explicit abort.
  assign cancel = (state_q != ST_IDLE) && (i_abort || !i_halted);

  always_comb begin
    state_d     = state_q;
    reg_idx_d   = reg_idx_q;
    ser_load    = 1'b0;
    ser_advance = 1'b0;
    ser_clear   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start && i_halted) begin
          state_d   = ST_READ;
          reg_idx_d = '0;
        end
      end
      ST_READ:  state_d = ST_LATCH;
      ST_LATCH: begin
        // Bank data for the READ-cycle request is present now.
        ser_load = 1'b1;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        if (!bus.i_tx_busy) state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (bus.i_tx_done) begin
          if (!ser_last) begin
            ser_advance = 1'b1;
            state_d     = ST_SEND;
          end else if (reg_idx_q < LAST_REG) begin
            reg_idx_d = reg_idx_q + ADDR_SIZE'(1);
            state_d   = ST_READ;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Cancel overrides everything, including a coincident i_tx_done.
    if (cancel) begin
      state_d     = ST_IDLE;
      reg_idx_d   = '0;
      ser_load    = 1'b0;
      ser_advance = 1'b0;
      ser_clear   = 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= ST_IDLE;
      reg_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      reg_idx_q <= reg_idx_d;
    end
  end

  always_comb begin
    bus.o_bank_read_enable = (state_q == ST_READ);
    bus.o_bank_read_addr   = (state_q == ST_IDLE) ? '0 : reg_idx_q;
    // Never launch a byte in a cycle that is being cancelled.
    bus.o_tx_start         = (state_q == ST_SEND) && !bus.i_tx_busy && !cancel;
    bus.o_tx_data          = ((state_q == ST_SEND) || (state_q == ST_WAIT_TX)) ?
                             ser_byte : '0;
    o_busy                 = (state_q != ST_IDLE);
    o_done                 = (state_q == ST_DONE) && !cancel;
    o_state_dbg            = state_q;
  end

endmodule

// File: tb/tb_reg_bank_dump_ctrl.sv
module tb_reg_bank_dump_ctrl;
  import reg_bank_dump_ctrl_pkg::*;

  localparam int DS    = 32;
  localparam int AS    = 5;
  localparam int BD    = 32;
  localparam int BS    = 8;
  localparam int BPW   = DS / BS;
  localparam int TOTAL = BD * BPW;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start, i_halted, i_abort;
  logic        o_busy, o_done;
  dump_state_t o_state_dbg;

  always #5 clk = ~clk;

  reg_bank_dump_ctrl_if #(.DATA_SIZE(DS), .ADDR_SIZE(AS), .BYTE_SIZE(BS)) bus ();

  reg_bank_dump_ctrl #(
    .DATA_SIZE(DS), .ADDR_SIZE(AS), .BANK_DEPTH(BD), .BYTE_SIZE(BS)
  ) dut (
    .i_clock     (clk),
    .i_reset     (rst_n),
    .i_start     (i_start),
    .i_halted    (i_halted),
    .i_abort     (i_abort),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_state_dbg (o_state_dbg),
    .bus         (bus)
  );

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] bank[BD];
  int          rd_exp_addr = 0;
  int          rd_pulses = 0;
  int          tx_count = 0;
  int          done_cnt = 0;
  int          abort_at = -1;
  int          hold_at = -1;
  bit          busy_rand = 1'b0;
  bit          rst_event = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- bank model: registered read, 1-cycle latency ----------------
  initial begin
    logic       re;
    logic [4:0] a;
    bus.i_bank_data = '0;
    forever begin
      @(negedge clk);
      re = bus.o_bank_read_enable;
      a  = bus.o_bank_read_addr;
      @(posedge clk);
      #1;
      bus.i_bank_data = re ? bank[a] : $urandom;
    end
  end

  // ---------------- UART TX model ----------------
  initial begin
    logic [7:0] held;
    int         idx;
    int         blen;
    bus.i_tx_busy = 1'b0;
    bus.i_tx_done = 1'b0;
    i_abort       = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.o_tx_start) begin
        held = bus.o_tx_data;
        idx  = tx_count;
        tx_count++;
        blen = busy_rand ? $urandom_range(1, 4) : 3;
        @(posedge clk); #1 bus.i_tx_busy = 1'b1;
        repeat (blen - 1) @(posedge clk);
        @(posedge clk); #1;
        bus.i_tx_busy = 1'b0;
        bus.i_tx_done = 1'b1;
        if (idx == abort_at) i_abort = 1'b1;
        @(negedge clk);
        if (!rst_event) check("tx_data_stable", bus.o_tx_data, held);
        @(posedge clk); #1;
        bus.i_tx_done = 1'b0;
        i_abort       = 1'b0;
        if (idx == abort_at) begin
          @(negedge clk);
          check("abort_busy", o_busy, 0);
          check("abort_state", o_state_dbg, ST_IDLE);
        end
        if (idx + 1 == hold_at) begin
          bus.i_tx_busy = 1'b1;
          repeat (10) @(posedge clk);
          #1 bus.i_tx_busy = 1'b0;
        end
      end
    end
  end

  // ---------------- monitors ----------------
  initial forever begin
    @(negedge clk);
    if (bus.o_tx_start) begin
      check("start_while_busy", bus.i_tx_busy, 0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_byte: got 0x%0h with no byte expected", bus.o_tx_data);
      end else begin
        check("tx_byte", bus.o_tx_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic prev_re = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.o_bank_read_enable) begin
        check("read_addr", bus.o_bank_read_addr, rd_exp_addr);
        check("read_single_cycle", prev_re, 0);
        rd_exp_addr++;
        rd_pulses++;
      end
      prev_re = bus.o_bank_read_enable;
    end
  end

  initial begin
    logic prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_done) check("busy_after_done", o_busy, 0);
      if (o_done) begin
        done_cnt++;
        check("busy_during_done", o_busy, 1);
      end
      prev_done = o_done;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic start_dump(input bit pattern, input int abort_byte, input int hold_byte);
    int n;
    for (int k = 0; k < BD; k++) bank[k] = pattern ? (32'h0A0B0C00 + k) : $urandom;
    n = (abort_byte >= 0) ? abort_byte + 1 : TOTAL;
    for (int b = 0; b < n; b++) exp_q.push_back(bank[b / BPW][(b % BPW) * BS +: BS]);
    rd_exp_addr = 0;
    rd_pulses   = 0;
    tx_count    = 0;
    abort_at    = abort_byte;
    hold_at     = hold_byte;
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles, input int restart_at);
    int c = 0;
    while (1) begin
      @(negedge clk);
      c++;
      if (!o_busy) break;
      if (c >= max_cycles) begin
        n_cmp++;
        n_fail++;
        $display("FAIL dump_timeout: still busy after %0d cycles, required idle", c);
        break;
      end
      if (c == restart_at) begin
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c;
    rst_n    = 1'b0;
    i_start  = 1'b0;
    i_halted = 1'b1;
    #12;
    check("rst_read_en", bus.o_bank_read_enable, 0);
    check("rst_read_addr", bus.o_bank_read_addr, 0);
    check("rst_tx_start", bus.o_tx_start, 0);
    check("rst_tx_data", bus.o_tx_data, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_state", o_state_dbg, ST_IDLE);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // start while not halted is ignored
    i_halted = 1'b0;
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    repeat (5) @(negedge clk);
    check("unhalted_busy", o_busy, 0);
    check("unhalted_reads", rd_pulses, 0);
    i_halted = 1'b1;

    // full dump, pattern data, busy hold before byte 5, restart attempt mid-dump
    start_dump(1'b1, -1, 5);
    wait_idle(20000, 150);
    check("d1_done_cnt", done_cnt, 1);
    check("d1_bytes", tx_count, TOTAL);
    check("d1_reads", rd_pulses, BD);
    check("d1_left", exp_q.size(), 0);

    // random data and TX timing, abort at reg 7 byte 2 together with tx_done
    busy_rand = 1'b1;
    start_dump(1'b0, 7 * BPW + 2, -1);
    wait_idle(20000, -1);
    check("ab_done_cnt", done_cnt, 1);
    check("ab_bytes", tx_count, 7 * BPW + 3);
    check("ab_reads", rd_pulses, 8);
    check("ab_left", exp_q.size(), 0);

    // restart after abort must begin at reg 0 byte 0
    start_dump(1'b0, -1, -1);
    wait_idle(20000, -1);
    check("d3_done_cnt", done_cnt, 2);
    check("d3_bytes", tx_count, TOTAL);
    check("d3_reads", rd_pulses, BD);
    check("d3_left", exp_q.size(), 0);

    // asynchronous reset in the middle of WAIT_TX
    start_dump(1'b0, -1, -1);
    c = 0;
    while (!(o_state_dbg == ST_WAIT_TX && tx_count >= 6) && c < 5000) begin
      @(negedge clk);
      c++;
    end
    check("rst_mid_reached", (c < 5000), 1);
    #2;
    rst_event = 1'b1;
    rst_n     = 1'b0;
    #1;
    exp_q.delete();
    check("amid_read_en", bus.o_bank_read_enable, 0);
    check("amid_read_addr", bus.o_bank_read_addr, 0);
    check("amid_tx_start", bus.o_tx_start, 0);
    check("amid_tx_data", bus.o_tx_data, 0);
    check("amid_busy", o_busy, 0);
    check("amid_done", o_done, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("post_rst_busy", o_busy, 0);
    check("post_rst_state", o_state_dbg, ST_IDLE);
    check("post_rst_done_cnt", done_cnt, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bank_dump_ctrl.md
Name: reg_bank_dump_ctrl

Overview:
Debug-unit sequencer that dumps the whole register bank over the UART transmitter while the pipeline is halted. It walks register addresses 0..BANK_DEPTH-1, drives the bank's debug read port (read_enable/read_addr), and captures each word one cycle later. It then streams each word to the TX block as DATA_SIZE/BYTE_SIZE bytes, least-significant byte first, using a start/done handshake. It sits between the debug unit's command FSM, the ID-stage register bank and the UART TX.

Parameters:
DATA_SIZE, 32, register width in bits
ADDR_SIZE, 5, register address width
BANK_DEPTH, 32, number of registers dumped
BYTE_SIZE, 8, TX byte width; DATA_SIZE must be a multiple of it

Ports:
i_clock  in  1  system clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_start  in  1  dump request pulse from debug FSM
i_halted  in  1  pipeline halted (bank i_enable low); required to accept i_start
i_abort  in  1  cancel an in-progress dump
i_bank_data  in  DATA_SIZE  bank read data (o_data_a), valid 1 cycle after read request
i_tx_busy  in  1  UART TX busy
i_tx_done  in  1  UART TX byte-finished pulse
o_bank_read_enable  out  1  bank debug read enable
o_bank_read_addr  out  ADDR_SIZE  bank debug read address
o_tx_start  out  1  one-cycle TX start pulse
o_tx_data  out  BYTE_SIZE  byte to transmit, stable from start until done
o_busy  out  1  dump in progress
o_done  out  1  one-cycle pulse when the dump completes

Behaviour:
- Reset (i_reset=0, async): state IDLE; reg_idx=0, byte_idx=0, word latch=0; all outputs 0.
- IDLE:
  - i_start && i_halted -> READ; reg_idx=0.
  - i_start while !i_halted is ignored.
- READ, 1 cycle:
  - o_bank_read_enable=1, o_bank_read_addr=reg_idx.
  - Next state LATCH.
- LATCH, 1 cycle:
  - Capture i_bank_data into the word latch; byte_idx=0.
  - Next state SEND.
  - Bank read latency is exactly one cycle.
- SEND:
  - While i_tx_busy=1, hold.
  - When i_tx_busy=0: o_tx_start=1 for exactly that cycle; o_tx_data = word[byte_idx*BYTE_SIZE +: BYTE_SIZE]; next state WAIT_TX.
- WAIT_TX:
  - Hold o_tx_data.
  - On i_tx_done:
    - If byte_idx < last, increment byte_idx and go to SEND.
    - Else if reg_idx < BANK_DEPTH-1, increment reg_idx and go to READ.
    - Else go to DONE.
- DONE, 1 cycle: o_done=1; next state IDLE.
- o_busy=1 in every state except IDLE; o_busy=0 in the cycle o_done is high is not allowed, so o_busy stays 1 during DONE.
- o_bank_read_enable is high only in READ; o_bank_read_addr holds reg_idx in all non-IDLE states and is 0 in IDLE.
- i_start while busy is ignored; no queuing.
- i_tx_done outside WAIT_TX is ignored.
- If i_tx_done coincides with the o_tx_start cycle, it is ignored because the state is still SEND.
- i_abort in any non-IDLE state:
  - Next state IDLE and counters cleared; no o_done.
  - A byte already started on TX is not recalled.
  - i_abort has priority over i_tx_done in the same cycle.
- i_halted falling mid-dump: treated as abort.
- Counter widths:
  - reg_idx is ADDR_SIZE wide and never wraps; the terminal compare is against BANK_DEPTH-1.
  - byte_idx is clog2(DATA_SIZE/BYTE_SIZE) wide, with a minimum of 1 bit.
- Total bytes per dump = BANK_DEPTH*DATA_SIZE/BYTE_SIZE, i.e. 128 at the defaults.

Decomposition:
- Shared debug package holds:
  - State encoding: IDLE, READ, LATCH, SEND, WAIT_TX, DONE (3-bit localparams).
  - BYTES_PER_WORD = DATA_SIZE/BYTE_SIZE.
- Natural sub-module: word_serializer. It holds the word latch and byte_idx, and produces the byte mux and the last_byte flag.
- The FSM stays in reg_bank_dump_ctrl.

Test Plan:
- Bank preloaded with reg[k]=32'h0A0B0C00+k, i_halted=1, pulse i_start, TX model with 3-cycle busy and done -> 128 bytes captured. Bytes 0..3 are 00,0C,0B,0A; bytes 124..127 are 1F,0C,0B,0A. o_done pulses exactly once; o_busy falls on the cycle after DONE.
- Read timing -> o_bank_read_enable is high for exactly 1 cycle per register, 32 pulses total, with addr 0..31 in order. The word is captured the cycle after each pulse.
- i_tx_busy held 1 for 10 cycles before byte 5 -> o_tx_start is delayed until busy falls, then pulses once. o_tx_data=8'h0C for reg 1, byte 1.
- i_start with i_halted=0 -> stays IDLE, o_busy=0. i_start pulsed again mid-dump -> no restart; byte count is still 128.
- i_abort asserted at reg 7, byte 2, with a simultaneous i_tx_done -> IDLE next cycle, no o_done. A new i_start restarts from reg 0, byte 0.
- i_reset driven low asynchronously mid-WAIT_TX -> all outputs 0 immediately. After release, the block waits in IDLE for i_start.
